ram_sp_bist: RTL and testbench

- March C- built-in self-test controller that sits directly upstream of the 16-bit single-port RAM and drives its we/addr/din ports.
- Consumes the RAM's registered dout and compares it against expected data.
- When not testing, user write/read traffic passes straight through to the RAM.
- Reports done, pass/fail, the first failing address and data, and an error count.

---
 rtl/ram_bist_pkg.sv | 19 +
 rtl/ram_bist_cmp.sv | 81 ++++++++
 rtl/ram_sp_bist.sv | 147 ++++++++++++++
 tb/tb_ram_sp_bist.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bist_pkg.sv
// Shared types and March C- element tables for the single-port RAM BIST.
package ram_bist_pkg;

   typedef enum logic [2:0] {E0, E1, E2, E3, E4, E5} elem_e;
   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_e;

   localparam int ERRCNT_W = 8;

   // Bit i of each table describes element Ei; bits 7:6 are unused padding.
   localparam logic [7:0] EL_DOWN = 8'b0001_1000;
   localparam logic [7:0] EL_RD   = 8'b0011_1110;
   localparam logic [7:0] EL_RPOL = 8'b0001_0100;
   localparam logic [7:0] EL_WPOL = 8'b0000_1010;

   function automatic logic el_bit(input logic [7:0] tbl, input elem_e e);
      return tbl[e];
   endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// Read-compare pipeline: one-cycle delayed compare, first-fail capture,
// saturating mismatch counter.
module ram_bist_cmp
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                rd_issue,
   input  logic [DATA_W-1:0]   rd_exp,
   input  logic [ADDR_W-1:0]   rd_addr,
   input  logic [DATA_W-1:0]   mem_dout,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data,
   output logic [DATA_W-1:0]   fail_exp,
   output logic [ERRCNT_W-1:0] err_count
);

   logic                cmp_pend_q, cmp_pend_d;
   logic [DATA_W-1:0]   exp_q, exp_d;
   logic [ADDR_W-1:0]   addr_d_q, addr_d_d;
   logic [ADDR_W-1:0]   faddr_q, faddr_d;
   logic [DATA_W-1:0]   fdata_q, fdata_d;
   logic [DATA_W-1:0]   fexp_q, fexp_d;
   logic [ERRCNT_W-1:0] cnt_q, cnt_d;
   logic                mism;

   always_comb begin
      cmp_pend_d = rd_issue & ~clr;
      exp_d      = rd_issue ? rd_exp : exp_q;
      addr_d_d   = rd_issue ? rd_addr : addr_d_q;
      faddr_d    = faddr_q;
      fdata_d    = fdata_q;
      fexp_d     = fexp_q;
      cnt_d      = cnt_q;
      mism       = cmp_pend_q && (mem_dout != exp_q);
      if (clr) begin
         faddr_d = '0;
         fdata_d = '0;
         fexp_d  = '0;
         cnt_d   = '0;
      end else if (mism) begin
         // A zero count means this is the first mismatch since start.
         if (cnt_q == '0) begin
            faddr_d = addr_d_q;
            fdata_d = mem_dout;
            fexp_d  = exp_q;
         end
         if (cnt_q != '1) cnt_d = cnt_q + ERRCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmp_pend_q <= 1'b0;
         exp_q      <= '0;
         addr_d_q   <= '0;
         faddr_q    <= '0;
         fdata_q    <= '0;
         fexp_q     <= '0;
         cnt_q      <= '0;
      end else begin
         cmp_pend_q <= cmp_pend_d;
         exp_q      <= exp_d;
         addr_d_q   <= addr_d_d;
         faddr_q    <= faddr_d;
         fdata_q    <= fdata_d;
         fexp_q     <= fexp_d;
         cnt_q      <= cnt_d;
      end
   end

   assign fail_addr = faddr_q;
   assign fail_data = fdata_q;
   assign fail_exp  = fexp_q;
   assign err_count = cnt_q;

endmodule

// File: rtl/ram_sp_bist.sv
// March C- BIST controller in front of a single-port RAM, with user
// pass-through while idle.
module ram_sp_bist
   import ram_bist_pkg::*;
#(
   parameter int                ADDR_W = 8,
   parameter int                DATA_W = 16,
   parameter logic [DATA_W-1:0] BG     = {DATA_W{1'b0}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                usr_we,
   input  logic [ADDR_W-1:0]   usr_addr,
   input  logic [DATA_W-1:0]   usr_din,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_din,
   input  logic [DATA_W-1:0]   mem_dout,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic [ADDR_W-1:0]   fail_addr,
   output logic [DATA_W-1:0]   fail_data,
   output logic [DATA_W-1:0]   fail_exp,
   output logic [ERRCNT_W-1:0] err_count
);

   localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

   state_e            state_q, state_d;
   elem_e             elem_q, elem_d, next_e;
   logic [ADDR_W-1:0] acnt_q, acnt_d;
   logic              phase_q, phase_d;
   logic              fin_q, fin_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              clr, rd_issue, bist_we;
   logic              has_rd, has_wr, down, term;
   logic [DATA_W-1:0] bist_din, rd_exp;

   always_comb begin
      state_d  = state_q;
      elem_d   = elem_q;
      acnt_d   = acnt_q;
      phase_d  = phase_q;
      fin_d    = 1'b0;
      done_d   = done_q;
      pass_d   = pass_q;
      clr      = 1'b0;
      rd_issue = 1'b0;
      has_rd   = el_bit(EL_RD, elem_q);
      has_wr   = (elem_q != E5);
      down     = el_bit(EL_DOWN, elem_q);
      rd_exp   = el_bit(EL_RPOL, elem_q) ? ~BG : BG;
      bist_din = el_bit(EL_WPOL, elem_q) ? ~BG : BG;
      bist_we  = !(has_rd && !phase_q);
      term     = down ? (acnt_q == '0) : (acnt_q == LAST);
      next_e   = elem_e'(elem_q + 3'd1);
      unique case (state_q)
         IDLE: begin
            // Final verdict is taken one edge after FLUSH so err_count is settled.
            if (fin_q) begin
               done_d = 1'b1;
               pass_d = (err_count == '0);
            end else if (start) begin
               state_d = RUN;
               elem_d  = E0;
               acnt_d  = '0;
               phase_d = 1'b0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               clr     = 1'b1;
            end
         end
         RUN: begin
            rd_issue = has_rd && !phase_q;
            if (rd_issue && has_wr) begin
               phase_d = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (term) begin
                  if (elem_q == E5) begin
                     state_d = FLUSH;
                  end else begin
                     elem_d = next_e;
                     acnt_d = el_bit(EL_DOWN, next_e) ? LAST : '0;
                  end
               end else begin
                  acnt_d = down ? acnt_q - ADDR_W'(1)
                                : acnt_q + ADDR_W'(1);
               end
            end
         end
         FLUSH: begin
            state_d = IDLE;
            fin_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         elem_q  <= E0;
         acnt_q  <= '0;
         phase_q <= 1'b0;
         fin_q   <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         elem_q  <= elem_d;
         acnt_q  <= acnt_d;
         phase_q <= phase_d;
         fin_q   <= fin_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   ram_bist_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_cmp (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .rd_issue  (rd_issue),
      .rd_exp    (rd_exp),
      .rd_addr   (acnt_q),
      .mem_dout  (mem_dout),
      .fail_addr (fail_addr),
      .fail_data (fail_data),
      .fail_exp  (fail_exp),
      .err_count (err_count)
   );

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign pass     = pass_q;
   assign mem_we   = busy ? bist_we  : usr_we;
   assign mem_addr = busy ? acnt_q   : usr_addr;
   assign mem_din  = busy ? bist_din : usr_din;

endmodule

// File: tb/tb_ram_sp_bist.sv
// Directed bench for ram_sp_bist with behavioural single-port RAMs.
module tb_ram_sp_bist;

   localparam int N    = 256;
   localparam int NOPS = 10 * N;
   localparam logic [15:0] BG2 = 16'hA5A5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        start_bg = 1'b0;
   logic        usr_we = 1'b0;
   logic [7:0]  usr_addr = 8'h00;
   logic [15:0] usr_din = 16'h0000;
   logic        stuck = 1'b0;

   logic        mem_we, busy, done, pass;
   logic [7:0]  mem_addr, fail_addr, err_count;
   logic [15:0] mem_din, mem_dout, fail_data, fail_exp;

   logic        b_we, b_busy, b_done, b_pass;
   logic [7:0]  b_addr, b_faddr, b_err;
   logic [15:0] b_din, b_dout, b_fdata, b_fexp;

   logic [15:0] ram_a [N];
   logic [15:0] ram_b [N];

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   ram_sp_bist dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .usr_we(usr_we), .usr_addr(usr_addr), .usr_din(usr_din),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
      .mem_dout(mem_dout), .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_data(fail_data),
      .fail_exp(fail_exp), .err_count(err_count)
   );

   ram_sp_bist #(.BG(BG2)) dut_bg (
      .clk(clk), .rst_n(rst_n), .start(start_bg),
      .usr_we(usr_we), .usr_addr(usr_addr), .usr_din(usr_din),
      .mem_we(b_we), .mem_addr(b_addr), .mem_din(b_din),
      .mem_dout(b_dout), .busy(b_busy), .done(b_done), .pass(b_pass),
      .fail_addr(b_faddr), .fail_data(b_fdata),
      .fail_exp(b_fexp), .err_count(b_err)
   );

   // RAM A optionally has bit 3 of address 0x5A stuck at 1.
   always @(posedge clk) begin
      if (mem_we) ram_a[mem_addr] <= mem_din;
      else if (stuck && mem_addr == 8'h5A) mem_dout <= ram_a[mem_addr] | 16'h0008;
      else mem_dout <= ram_a[mem_addr];
   end

   always @(posedge clk) begin
      if (b_we) ram_b[b_addr] <= b_din;
      else b_dout <= ram_b[b_addr];
   end

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference March C- operation k (0-based from the first op).
   function automatic void exp_op(input int k, input logic [15:0] bg,
                                  output logic we, output logic [7:0] a,
                                  output logic [15:0] d);
      int r, idx;
      r = k;
      d = 16'h0000;
      if (r < N) begin
         we = 1'b1; a = 8'(r); d = bg;
         return;
      end
      r -= N;
      for (int e = 1; e <= 4; e++) begin
         if (r < 2 * N) begin
            idx = r / 2;
            a   = (e >= 3) ? 8'(N - 1 - idx) : 8'(idx);
            we  = (r % 2) == 1;
            d   = (e == 1 || e == 3) ? ~bg : bg;
            return;
         end
         r -= 2 * N;
      end
      we = 1'b0; a = 8'(r);
   endfunction

   task automatic do_run(input int restart_at, input int abort_at,
                         input bit chk_bg, output int done_edge,
                         output int seq_err);
      logic        ewe;
      logic [7:0]  ea;
      logic [15:0] ed;
      done_edge = -1;
      seq_err   = 0;
      start     = 1'b1;
      start_bg  = chk_bg;
      tick();
      start    = 1'b0;
      start_bg = 1'b0;
      chk("busy_after_start", busy, 1);
      for (int k = 0; k < 3000; k++) begin
         start = (k == restart_at);
         if (k == abort_at) begin
            usr_addr = 8'h77;
            rst_n = 1'b0;
            #1;
            chk("abort_busy", busy, 0);
            chk("abort_done", done, 0);
            chk("abort_pass", pass, 0);
            chk("abort_err", err_count, 0);
            chk("abort_addr", mem_addr, 8'h77);
            rst_n = 1'b1;
            done_edge = k;
            break;
         end
         if (k < NOPS) begin
            exp_op(k, 16'h0000, ewe, ea, ed);
            if (mem_we !== ewe || mem_addr !== ea ||
                (ewe && mem_din !== ed)) seq_err++;
         end
         if (chk_bg && k == 0) chk("bg_e0_din", {b_we, b_din}, {1'b1, BG2});
         if (chk_bg && k == N + 1)
            chk("bg_e1_din", {b_we, b_addr, b_din}, {1'b1, 8'h00, ~BG2});
         if (done) begin
            done_edge = k;
            break;
         end
         tick();
      end
      start = 1'b0;
   endtask

   typedef struct {
      logic        we;
      logic [7:0]  a;
      logic [15:0] d;
      logic        chk_q;
      logic [15:0] q;
   } vec_t;

   vec_t tv [6];
   int   de, se;

   initial begin
      tv[0] = '{1'b1, 8'h10, 16'h1234, 1'b0, 16'h0000};
      tv[1] = '{1'b1, 8'h11, 16'hBEEF, 1'b0, 16'h0000};
      tv[2] = '{1'b0, 8'h10, 16'h0000, 1'b1, 16'h1234};
      tv[3] = '{1'b0, 8'h11, 16'h0000, 1'b1, 16'hBEEF};
      tv[4] = '{1'b1, 8'h10, 16'h0000, 1'b1, 16'hBEEF};
      tv[5] = '{1'b0, 8'h10, 16'h5555, 1'b1, 16'h0000};

      usr_addr = 8'h33;
      tick();
      tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_fail", {fail_addr, fail_data, fail_exp}, 0);
      chk("rst_mux", mem_addr, 8'h33);
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 6; i++) begin
         usr_we = tv[i].we; usr_addr = tv[i].a; usr_din = tv[i].d;
         #1;
         chk($sformatf("pt_mux%0d", i), {mem_we, mem_addr, mem_din},
             {tv[i].we, tv[i].a, tv[i].d});
         tick();
         chk($sformatf("pt_busy%0d", i), busy, 0);
         if (tv[i].chk_q) chk($sformatf("pt_dout%0d", i), mem_dout, tv[i].q);
      end
      usr_we = 1'b0;
      tick();

      do_run(-1, -1, 1'b1, de, se);
      chk("clean_done_edge", de, 2562);
      chk("clean_seq", se, 0);
      chk("clean_pass", {busy, pass, err_count, fail_addr}, {1'b0, 1'b1, 16'h0});
      chk("bg_pass", {b_done, b_pass, b_err}, {2'b11, 8'h00});
      tick();

      stuck = 1'b1;
      do_run(-1, -1, 1'b0, de, se);
      chk("stuck_done_edge", de, 2562);
      chk("stuck_pass", pass, 0);
      chk("stuck_err", err_count, 3);
      chk("stuck_faddr", fail_addr, 8'h5A);
      chk("stuck_fdata", fail_data, 16'h0008);
      chk("stuck_fexp", fail_exp, 16'h0000);
      stuck = 1'b0;
      tick();

      do_run(500, -1, 1'b0, de, se);
      chk("restart_done_edge", de, 2562);
      chk("restart_seq", se, 0);
      chk("restart_pass_clears_err", {pass, err_count}, {1'b1, 8'h00});
      tick();

      do_run(-1, 1000, 1'b0, de, se);
      tick();
      do_run(-1, -1, 1'b0, de, se);
      chk("after_abort_done_edge", de, 2562);
      chk("after_abort_pass", {done, pass, err_count}, {2'b11, 8'h00});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
